// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction memory: opcodes, instruction layout,
// default program image and bus unit selects.
package instr_pkg;

    localparam int unsigned InstrW = 32;

    typedef enum logic [7:0] {
        OpMmult      = 8'h00,
        OpMadd       = 8'h01,
        OpMsub       = 8'h02,
        OpMtranspose = 8'h03,
        OpMscale     = 8'h04,
        OpMscaleImm  = 8'h05,
        OpIntAdd     = 8'h10,
        OpIntSub     = 8'h11,
        OpIntMult    = 8'h12,
        OpIntDiv     = 8'h13,
        OpStop       = 8'hFF
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    localparam instr_t STOP_WORD = '{opcode: OpStop, dest: 8'h00, src1: 8'h00, src2: 8'h00};
    // MADD m2 <- m0 + m1, then halt.
    localparam instr_t IMG0      = '{opcode: OpMadd, dest: 8'h02, src1: 8'h00, src2: 8'h01};
    localparam instr_t IMG1      = STOP_WORD;

    localparam logic [3:0] InstrMemEn  = 4'h1;
    localparam logic [3:0] DataMemEn   = 4'h2;
    localparam logic [3:0] MatrixAluEn = 4'h3;
    localparam logic [3:0] IntAluEn    = 4'h4;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } mem_state_e;

    function automatic logic [InstrW-1:0] init_word(input int unsigned idx);
        case (idx)
            0:       return IMG0;
            1:       return IMG1;
            default: return STOP_WORD;
        endcase
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// A same-edge read of the word being written returns the old contents.
module instr_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value between reads so the output path can rely on it.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: bus decode, post-reset image sweep, pipelined reads with
// DataValid/AddrErr strobes, and an optional host write port.
module instr_mem_ctrl
    import instr_pkg::*;
#(
    parameter int unsigned             DATA_W   = 32,
    parameter int unsigned             ADDR_W   = 16,
    parameter int unsigned             IDX_W    = 12,
    parameter int unsigned             DEPTH    = 256,
    parameter logic [ADDR_W-IDX_W-1:0] UNIT_ID  = InstrMemEn,
    parameter int unsigned             RD_LAT   = 2,
    parameter bit                      WRITABLE = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              nRead,
    input  logic              nWrite,
    input  logic [DATA_W-1:0] Datain,
    output logic [DATA_W-1:0] Dataout,
    output logic              DataValid,
    output logic              AddrErr,
    output logic              Busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    logic [ADDR_W-IDX_W-1:0] unit_sel;
    logic [IDX_W-1:0]        loc_idx;
    logic                    in_range;
    logic                    busy;
    logic                    sel;
    logic                    rd_acc;
    logic                    wr_acc;

    logic              arr_we;
    logic [AW-1:0]     arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] err_q, err_d;
    logic [DATA_W-1:0] s0_data;
    logic [DATA_W-1:0] out_data;

    assign unit_sel = address[ADDR_W-1:IDX_W];
    assign loc_idx  = address[IDX_W-1:0];
    assign in_range = 32'(loc_idx) < DEPTH;
    assign busy     = (state_q == StInit);
    assign sel      = (unit_sel == UNIT_ID) && !busy;
    assign rd_acc   = sel && !nRead;
    assign wr_acc   = sel && !nWrite && WRITABLE && in_range;

    // Init sweep owns the write port while Busy; host writes cannot occur then.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        arr_we    = wr_acc;
        arr_waddr = loc_idx[AW-1:0];
        arr_wdata = Datain;
        unique case (state_q)
            StInit: begin
                arr_we    = 1'b1;
                arr_waddr = idx_q;
                arr_wdata = DATA_W'(init_word(32'(idx_q)));
                idx_d     = idx_q + AW'(1);
                if (32'(idx_q) == DEPTH - 1) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StInit;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (rd_acc && in_range),
        .raddr_i (loc_idx[AW-1:0]),
        .rdata_o (arr_rdata)
    );

    // Stage 0 is the array read; err bits hold with the data so a held STOP_WORD stays put.
    always_comb begin
        vld_d    = '0;
        err_d    = err_q;
        vld_d[0] = rd_acc;
        if (rd_acc) begin
            err_d[0] = !in_range;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                err_d[k] = err_q[k-1];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    assign s0_data = err_q[0] ? DATA_W'(STOP_WORD) : arr_rdata;

    if (RD_LAT > 1) begin : g_pipe
        logic [DATA_W-1:0] dat_q [RD_LAT-1];
        logic [DATA_W-1:0] dat_d [RD_LAT-1];

        always_comb begin
            dat_d    = dat_q;
            if (vld_q[0]) begin
                dat_d[0] = s0_data;
            end
            for (int k = 1; k < RD_LAT - 1; k++) begin
                if (vld_q[k]) begin
                    dat_d[k] = dat_q[k-1];
                end
            end
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    dat_q[k] <= '0;
                end
            end else begin
                dat_q <= dat_d;
            end
        end

        assign out_data = dat_q[RD_LAT-2];
    end else begin : g_nopipe
        assign out_data = s0_data;
    end

    assign Dataout   = out_data;
    assign DataValid = vld_q[RD_LAT-1];
    assign AddrErr   = vld_q[RD_LAT-1] & err_q[RD_LAT-1];
    assign Busy      = busy;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench: three instances (RD_LAT 2, RD_LAT 1, RD_LAT 4 ROM) share one stimulus stream;
// a negedge monitor logs every strobe so each read is checked for data, error flag and cycle.
module tb_instr_mem_ctrl;

    localparam int NDUT = 3;
    localparam logic [31:0] W_IMG0 = 32'h0102_0001;
    localparam logic [31:0] W_STOP = 32'hFF00_0000;
    localparam logic [31:0] W_T2   = 32'h1205_0304;
    localparam logic [31:0] W_T4   = 32'h0000_00AA;

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic [15:0]               address;
    logic                      nRead;
    logic                      nWrite;
    logic [31:0]               Datain;
    logic [NDUT-1:0][31:0]     dout;
    logic [NDUT-1:0]           dv;
    logic [NDUT-1:0]           ae;
    logic [NDUT-1:0]           busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat [NDUT] = '{2, 1, 4};

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        vld;
    } ev_t;

    ev_t mq [NDUT][$];

    instr_mem_ctrl #(.RD_LAT(2)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead), .nWrite(nWrite),
        .Datain(Datain), .Dataout(dout[0]), .DataValid(dv[0]), .AddrErr(ae[0]), .Busy(busy[0])
    );
    instr_mem_ctrl #(.RD_LAT(1)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead), .nWrite(nWrite),
        .Datain(Datain), .Dataout(dout[1]), .DataValid(dv[1]), .AddrErr(ae[1]), .Busy(busy[1])
    );
    instr_mem_ctrl #(.RD_LAT(4), .WRITABLE(1'b0)) u_dut_c (
        .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead), .nWrite(nWrite),
        .Datain(Datain), .Dataout(dout[2]), .DataValid(dv[2]), .AddrErr(ae[2]), .Busy(busy[2])
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (dv[k] || ae[k]) begin
                mq[k].push_back('{cyc, dout[k], ae[k], dv[k]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        address = 16'h0000;
        nRead   = 1'b1;
        nWrite  = 1'b1;
        Datain  = 32'h0;
    endtask

    // c is the cycle the request is presented in; a strobe is due in cycle c + latency.
    task automatic rd(input logic [15:0] a, output int c);
        c       = cyc;
        address = a;
        nRead   = 1'b0;
        nWrite  = 1'b1;
        tick();
        idle();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        address = a;
        Datain  = d;
        nRead   = 1'b1;
        nWrite  = 1'b0;
        tick();
        idle();
    endtask

    task automatic settle();
        repeat (8) tick();
    endtask

    task automatic expect_ev(input int k, input string tag, input logic [31:0] d, input logic e,
                             input int c);
        ev_t ev;
        chk($sformatf("%s[%0d].present", tag, k), 32'(mq[k].size() != 0), 32'd1);
        if (mq[k].size() != 0) begin
            ev = mq[k].pop_front();
            chk($sformatf("%s[%0d].valid", tag, k), {31'b0, ev.vld}, 32'd1);
            chk($sformatf("%s[%0d].data", tag, k), ev.data, d);
            chk($sformatf("%s[%0d].err", tag, k), {31'b0, ev.err}, {31'b0, e});
            chk($sformatf("%s[%0d].cycle", tag, k), 32'(ev.cyc), 32'(c + lat[k]));
        end
    endtask

    task automatic expect_empty(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s[%0d].no_strobe", tag, k), 32'(mq[k].size()), 32'd0);
            mq[k].delete();
        end
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (busy[0] && cnt < 300) begin
            // Reads offered during the sweep must be ignored.
            if (cnt < 10) begin
                address = 16'h1000;
                nRead   = 1'b0;
            end else begin
                idle();
            end
            cnt++;
            tick();
        end
        idle();
        chk({tag, ".busy_cycles"}, 32'(cnt), 32'd256);
        chk({tag, ".busy_low"}, {29'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] exp_word(input int k, input int i);
        if (i == 0) return W_IMG0;
        if (i == 3 && k != 2) return W_T2;
        return W_STOP;
    endfunction

    initial begin
        int c0, c1, c2;
        int cs [4];
        int ca [256];

        idle();
        Reset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst.dout[%0d]", k), dout[k], 32'h0);
        end
        chk("rst.valid", {29'b0, dv}, 32'd0);
        chk("rst.err", {29'b0, ae}, 32'd0);
        chk("rst.busy", {29'b0, busy}, 32'd7);
        Reset = 1'b0;

        // T1 + T5(busy part): sweep length, ignored reads, default image.
        wait_init("t1");
        expect_empty("t5.busy_read");
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("t5.busy_dout[%0d]", k), dout[k], 32'h0);
        end
        rd(16'h1000, c0);
        rd(16'h1001, c1);
        rd(16'h10C8, c2);
        settle();
        for (int k = 0; k < NDUT; k++) begin
            expect_ev(k, "t1.idx0", W_IMG0, 1'b0, c0);
            expect_ev(k, "t1.idx1", W_STOP, 1'b0, c1);
            expect_ev(k, "t1.idx200", W_STOP, 1'b0, c2);
        end
        expect_empty("t1.extra");

        // T2: write then four back-to-back reads; the ROM instance drops the write.
        wr(16'h1003, W_T2);
        for (int i = 0; i < 4; i++) begin
            rd(16'h1001 + 16'(i), cs[i]);
        end
        settle();
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 4; i++) begin
                expect_ev(k, $sformatf("t2.rd%0d", i), exp_word(k, i + 1), 1'b0, cs[i]);
            end
        end
        expect_empty("t2.extra");

        // T3: out-of-range read, then out-of-range write must not alias onto idx 0.
        rd(16'h1003, c0);
        rd(16'h1100, c1);
        settle();
        for (int k = 0; k < NDUT; k++) begin
            expect_ev(k, "t3.pre", exp_word(k, 3), 1'b0, c0);
            expect_ev(k, "t3.oor", W_STOP, 1'b1, c1);
        end
        wr(16'h1100, 32'h1234_5678);
        wr(16'h1FFF, 32'h8765_4321);
        for (int i = 0; i < 256; i++) begin
            rd(16'h1000 + 16'(i), ca[i]);
        end
        settle();
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 256; i++) begin
                expect_ev(k, $sformatf("t3.sweep%0d", i), exp_word(k, i), 1'b0, ca[i]);
            end
        end
        expect_empty("t3.extra");

        // T4: same-cycle read and write return the old word.
        c0      = cyc;
        address = 16'h1005;
        Datain  = W_T4;
        nRead   = 1'b0;
        nWrite  = 1'b0;
        tick();
        idle();
        rd(16'h1005, c1);
        settle();
        for (int k = 0; k < NDUT; k++) begin
            expect_ev(k, "t4.old", W_STOP, 1'b0, c0);
            expect_ev(k, "t4.new", (k != 2) ? W_T4 : W_STOP, 1'b0, c1);
        end

        // T5: wrong unit with both strobes low does nothing.
        address = 16'h2005;
        Datain  = 32'hDEAD_BEEF;
        nRead   = 1'b0;
        nWrite  = 1'b0;
        tick();
        idle();
        settle();
        expect_empty("t5.wrong_unit");
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("t5.hold[%0d]", k), dout[k], (k != 2) ? W_T4 : W_STOP);
        end
        rd(16'h1005, c0);
        settle();
        for (int k = 0; k < NDUT; k++) begin
            expect_ev(k, "t5.word5", (k != 2) ? W_T4 : W_STOP, 1'b0, c0);
        end

        // T6: reset between accept and strobe discards the read and re-images memory.
        rd(16'h1000, c0);
        Reset = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("t6.dout[%0d]", k), dout[k], 32'h0);
        end
        chk("t6.valid", {29'b0, dv}, 32'd0);
        chk("t6.busy", {29'b0, busy}, 32'd7);
        repeat (2) tick();
        Reset = 1'b0;
        wait_init("t6");
        settle();
        expect_empty("t6.discard");
        rd(16'h1005, c0);
        settle();
        for (int k = 0; k < NDUT; k++) begin
            expect_ev(k, "t6.word5", W_STOP, 1'b0, c0);
        end
        expect_empty("t6.extra");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
